// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I immediate-format selectors and shared width constants.
package riscv_pkg;
  localparam int XLEN = 32;
  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;
endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational RV32I immediate format mux; unsupported selectors yield zero and flag an error.
module imm_decode
  import riscv_pkg::*;
(
  input  logic [31:7]     instr,
  input  logic [2:0]      imm_src,
  output logic [XLEN-1:0] imm_ext,
  output logic            imm_src_err
);
  always_comb begin
    imm_ext = imm_src == IMM_I ? {{20{instr[31]}}, instr[31:20]} :
              imm_src == IMM_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
              imm_src == IMM_B ? {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
              imm_src == IMM_J ? {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0} :
              imm_src == IMM_U ? {instr[31:12], 12'b0} : '0;
    imm_src_err = imm_src > IMM_U;
  end
endmodule

// File: rtl/extend_unit.sv
// extend_unit: RV32I immediate generator; define EXTEND_OUTREG_EN to add a 1-cycle output register
// with asynchronous reset, otherwise the outputs are purely combinational.
module extend_unit
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [31:7]     instr,
  input  logic [2:0]      ImmSrc,
  output logic [XLEN-1:0] ImmExt,
  output logic            ImmSrcErr
);
  logic [XLEN-1:0] imm_ext;
  logic            imm_src_err;
  imm_decode u_imm_decode (
    .instr       (instr),
    .imm_src     (ImmSrc),
    .imm_ext     (imm_ext),
    .imm_src_err (imm_src_err)
  );
`ifdef EXTEND_OUTREG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ImmExt    <= '0;
      ImmSrcErr <= 1'b0;
    end else begin
      ImmExt    <= imm_ext;
      ImmSrcErr <= imm_src_err;
    end
  end
`else
  logic unused_clk_reset;
  assign unused_clk_reset = &{1'b0, clk, reset};
  assign ImmExt    = imm_ext;
  assign ImmSrcErr = imm_src_err;
`endif
endmodule

// File: tb/tb_extend_unit.sv
// tb_extend_unit: directed plus random checks of extend_unit against an arithmetic reference model.
module tb_extend_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:7] instr = '0;
  logic [2:0]  ImmSrc = '0;
  logic [31:0] ImmExt;
  logic        ImmSrcErr;
  int vectors = 0;
  int miscompares = 0;

  extend_unit dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .ImmSrc    (ImmSrc),
    .ImmExt    (ImmExt),
    .ImmSrcErr (ImmSrcErr)
  );

  always #5 clk = ~clk;

  function automatic longint fld(logic [31:0] w, int hi, int lo);
    return longint'((w >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1));
  endfunction

  // Immediate value built as a signed integer from weighted instruction fields.
  function automatic logic [32:0] ref_imm(logic [31:0] w, logic [2:0] s);
    longint v;
    longint sgn;
    sgn = w[31] ? 1 : 0;
    v = 0;
    if (s == 3'd0) v = fld(w, 30, 20) - sgn * 2048;
    else if (s == 3'd1) v = fld(w, 30, 25) * 32 + fld(w, 11, 7) - sgn * 2048;
    else if (s == 3'd2) v = fld(w, 7, 7) * 2048 + fld(w, 30, 25) * 32 + fld(w, 11, 8) * 2 - sgn * 4096;
    else if (s == 3'd3) v = fld(w, 19, 12) * 4096 + fld(w, 20, 20) * 2048 + fld(w, 30, 21) * 2 - sgn * 1048576;
    else if (s == 3'd4) v = fld(w, 31, 12) * 4096;
    return {s > 3'd4, v[31:0]};
  endfunction

  task automatic check(string tag, logic [31:0] exp_imm, logic exp_err);
    vectors++;
    assert (ImmExt === exp_imm && ImmSrcErr === exp_err) else begin
      miscompares++;
      $error("FAIL %s: got imm=%h err=%b expected imm=%h err=%b", tag, ImmExt, ImmSrcErr, exp_imm, exp_err);
    end
  endtask

  // Drive at the falling edge; registered build sees the result one rising edge later.
  task automatic apply(logic [31:0] w, logic [2:0] s);
    @(negedge clk);
    instr = w[31:7];
    ImmSrc = s;
`ifdef EXTEND_OUTREG_EN
    @(posedge clk);
`endif
    #1;
  endtask

  task automatic run(string tag, logic [31:0] w, logic [2:0] s);
    logic [32:0] r;
    r = ref_imm(w, s);
    apply(w, s);
    check(tag, r[31:0], r[32]);
  endtask

  task automatic run_exp(string tag, logic [31:0] w, logic [2:0] s, logic [31:0] exp_imm, logic exp_err);
    apply(w, s);
    check(tag, exp_imm, exp_err);
  endtask

  initial begin
    logic [31:0] w;
    logic [32:0] r;
`ifdef EXTEND_OUTREG_EN
    reset = 1'b1;
    #12;
    check("reset_init", 32'h0, 1'b0);
    reset = 1'b0;
`endif
    run_exp("i_neg",  32'h8000_0000, 3'b000, 32'hFFFFF800, 1'b0);
    run_exp("i_pos",  32'h07F0_0000, 3'b000, 32'h0000007F, 1'b0);
    run_exp("s_pos",  (32'h01 << 25) | (32'h04 << 7), 3'b001, 32'h00000024, 1'b0);
    run_exp("s_ones", (32'h7F << 25) | (32'h1F << 7), 3'b001, 32'hFFFFFFFF, 1'b0);
    run_exp("b_bit7", 32'h0000_0080, 3'b010, 32'h00000800, 1'b0);
    run_exp("b_neg",  32'h8000_0000, 3'b010, 32'hFFFFF000, 1'b0);
    run_exp("j_neg",  32'h8000_0000, 3'b011, 32'hFFF00000, 1'b0);
    run_exp("j_b20",  32'h0010_0000, 3'b011, 32'h00000800, 1'b0);
    run_exp("u_val",  32'h1234_5000, 3'b100, 32'h12345000, 1'b0);
    run_exp("u_low",  32'hFFFF_FFFF, 3'b100, 32'hFFFFF000, 1'b0);
    run_exp("b_ones", 32'hFFFF_FFFF, 3'b010, 32'hFFFFFFFE, 1'b0);
    run_exp("j_ones", 32'hFFFF_FFFF, 3'b011, 32'hFFFFFFFE, 1'b0);
    run_exp("bad101", 32'hFFFF_FFFF, 3'b101, 32'h0, 1'b1);
    run_exp("bad110", 32'hFFFF_FFFF, 3'b110, 32'h0, 1'b1);
    run_exp("bad111", 32'h1234_5678, 3'b111, 32'h0, 1'b1);
    for (int k = 0; k < 300; k++) begin
      w = $urandom;
      run("rand", w, 3'($urandom_range(0, 7)));
    end
`ifdef EXTEND_OUTREG_EN
    apply(32'h8000_0000, 3'b000);
    #2;
    reset = 1'b1;
    #1;
    check("reset_async", 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_hold", 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    w = 32'h1234_5000;
    instr = w[31:7];
    ImmSrc = 3'b100;
    #1;
    check("latency_pre", 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check("latency_post", 32'h12345000, 1'b0);
    @(negedge clk);
    w = $urandom;
    instr = w[31:7];
    ImmSrc = 3'b011;
    #1;
    check("latency_hold", 32'h12345000, 1'b0);
    r = ref_imm(w, 3'b011);
    @(posedge clk);
    #1;
    check("latency_next", r[31:0], r[32]);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/extend_unit.md
# extend_unit

Combinational RISC-V RV32I immediate generator in the decode stage of the pipelined core. It takes instruction bits [31:7] and the decoder's `ImmSrc` selector. It produces the 32-bit sign-extended, or upper-placed, immediate `ImmExt` consumed by the ALU source mux and the branch/jump target adder. An optional output register stage is selected at compile time.

## Interface
Parameters:
- none. All widths are fixed by RV32I.

Ports:
- `clk` input 1: single clock. Used only when the output register is compiled in.
- `reset` input 1: asynchronous, active-high reset.
- `instr` input 25: instruction bits [31:7], declared `[31:7]`.
- `ImmSrc` input 3: immediate format select.
- `ImmExt` output 32: extended immediate.
- `ImmSrcErr` output 1: high when `ImmSrc` is an unsupported encoding.

## Operation
`ImmSrc` encodings, with i = `instr`:
- 000, I-type: {{20{i[31]}}, i[31:20]}.
- 001, S-type: {{20{i[31]}}, i[31:25], i[11:7]}.
- 010, B-type: {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}.
- 011, J-type: {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}.
- 100, U-type: {i[31:12], 12'b0}.

Unsupported encodings:
- 101, 110, 111 drive `ImmExt` = 32'h0 and `ImmSrcErr` = 1.
- Never drive X.

Arithmetic rules:
- Sign extension always uses i[31].
- No other arithmetic is performed.
- B and J immediates always have bit 0 = 0.

Width rules:
- U-type low 12 bits are always 0.
- Bits [6:0] of the instruction are never needed and are not ports.

## Timing
Default build:
- Purely combinational, zero-cycle latency.
- Outputs settle within the same cycle as any input change.
- `clk` and `reset` are unused.
- No state exists, so there are no reset values.

Registered build (see Configuration):
- `ImmExt` and `ImmSrcErr` are captured on the rising edge of `clk`.
- Latency is exactly 1 cycle.
- `reset` asserted, at any time including mid-operation, forces `ImmExt` = 32'h0 and `ImmSrcErr` = 0 immediately, without waiting for a clock edge.
- Outputs hold those values until the first rising edge after `reset` deasserts.

Handshake: there is none. The block accepts new input every cycle.

## Configuration
Macro `EXTEND_OUTREG_EN`:
- Defined: the output register stage described in Timing is instantiated.
- Undefined: outputs are the combinational decode. The ports are identical in both builds.

## Structure
Package `riscv_pkg` holds:
- The `ImmSrc` enum / localparams: `IMM_I`=3'b000, `IMM_S`=3'b001, `IMM_B`=3'b010, `IMM_J`=3'b011, `IMM_U`=3'b100.
- The shared width constants: `XLEN`=32.

Sub-module:
- One sub-module is natural: `imm_decode`, the combinational format mux.
- `extend_unit` wraps `imm_decode` with the optional output register.

## Test plan
- I-type: i[31:20]=12'h800, ImmSrc=000 -> ImmExt=32'hFFFFF800. Then i[31:20]=12'h07F -> 32'h0000007F.
- S-type: i[31:25]=7'h01, i[11:7]=5'h04, i[31]=0, ImmSrc=001 -> 32'h00000024. Then i[31:25]=7'h7F, i[11:7]=5'h1F -> 32'hFFFFFFFF.
- B-type: only i[7]=1, ImmSrc=010 -> 32'h00000800. Then only i[31]=1 -> 32'hFFFFF000, with bit 0 always 0.
- J-type: only i[31]=1, ImmSrc=011 -> 32'hFFF00000. Then only i[20]=1 -> 32'h00000800.
- U-type and illegal encodings:
  - i[31:12]=20'h12345, ImmSrc=100 -> 32'h12345000.
  - ImmSrc=101/110/111 -> ImmExt=0, ImmSrcErr=1.
- Registered build: assert `reset` mid-run -> outputs are 0 without a clock edge. After release, the output appears exactly one `clk` edge after the input is applied.
